mprj_io_bank_ctrl: RTL and testbench

Parametrised configuration controller for the user-project GPIO pad bank. It holds per-pad drive mode (`dm`), output-enable and input-disable state in shadow registers written over a valid/ready port. On request, it applies the shadow state to the pads in staggered groups to limit simultaneous pad switching. It sits between housekeeping and the `mprj_io` pad array and optionally synchronises pad inputs back into the core clock domain.

---
 rtl/mprj_io_bank_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mprj_io_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_bank_ctrl.sv
// GPIO pad-bank configuration controller: shadow registers written over valid/ready,
// applied to the pads in staggered groups. Define MPRJ_IO_SYNC_EN to synchronise pad inputs.
module mprj_io_bank_ctrl #(
  parameter int         N_PADS = 38,
  parameter int         PAD_AW = 6,
  parameter int         GROUP  = 8,
  parameter logic [2:0] RST_DM = 3'b001
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [PAD_AW-1:0]     cfg_pad,
  input  logic [4:0]            cfg_data,
  output logic                  cfg_err,
  input  logic                  apply,
  output logic                  apply_busy,
  output logic                  apply_done,
  input  logic [PAD_AW-1:0]     rd_pad,
  output logic [4:0]            rd_data,
  input  logic [N_PADS-1:0]     io_in_raw,
  output logic [N_PADS-1:0]     io_in,
  output logic [N_PADS*3-1:0]   dm,
  output logic [N_PADS-1:0]     oeb,
  output logic [N_PADS-1:0]     inp_dis
);

  localparam int NG = (N_PADS + GROUP - 1) / GROUP;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [4:0]      RST_CFG = {1'b0, 1'b1, RST_DM};
  localparam logic [PAD_AW:0] NP_LIM  = (PAD_AW + 1)'(N_PADS);
  localparam logic [GW-1:0]   LAST_G  = GW'(NG - 1);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [4:0]      shadow_q [N_PADS];
  logic [4:0]      shadow_d [N_PADS];
  logic [4:0]      active_q [N_PADS];
  logic [4:0]      active_d [N_PADS];
  logic            cfg_err_q, cfg_err_d;
  logic            apply_done_q, apply_done_d;
  logic [4:0]      rd_data_q, rd_data_d;

  logic            wr_fire;
  logic            wr_in_range;

  assign cfg_ready   = (state_q == IDLE);
  assign apply_busy  = (state_q == APPLY);
  assign apply_done  = apply_done_q;
  assign cfg_err     = cfg_err_q;
  assign rd_data     = rd_data_q;
  assign wr_fire     = cfg_valid && cfg_ready;
  assign wr_in_range = ({1'b0, cfg_pad} < NP_LIM);

  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    apply_done_d = 1'b0;
    cfg_err_d    = wr_fire && !wr_in_range;
    rd_data_d    = '0;

    if (wr_fire && wr_in_range) begin
      for (int p = 0; p < N_PADS; p++) begin
        if (cfg_pad == PAD_AW'(p)) shadow_d[p] = cfg_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (apply) begin
          state_d = APPLY;
          grp_d   = '0;
        end
      end
      APPLY: begin
        // Only pads of the current group move; the rest of the bank holds.
        for (int p = 0; p < N_PADS; p++) begin
          if (grp_q == GW'(p / GROUP)) active_d[p] = shadow_q[p];
        end
        grp_d = grp_q + GW'(1);
        if (grp_q == LAST_G) begin
          state_d      = IDLE;
          grp_d        = '0;
          apply_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grp_d   = '0;
      end
    endcase

    for (int p = 0; p < N_PADS; p++) begin
      if (rd_pad == PAD_AW'(p)) rd_data_d = active_q[p];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      grp_q        <= '0;
      cfg_err_q    <= 1'b0;
      apply_done_q <= 1'b0;
      rd_data_q    <= '0;
      for (int p = 0; p < N_PADS; p++) begin
        shadow_q[p] <= RST_CFG;
        active_q[p] <= RST_CFG;
      end
    end else begin
      state_q      <= state_d;
      grp_q        <= grp_d;
      cfg_err_q    <= cfg_err_d;
      apply_done_q <= apply_done_d;
      rd_data_q    <= rd_data_d;
      for (int p = 0; p < N_PADS; p++) begin
        shadow_q[p] <= shadow_d[p];
        active_q[p] <= active_d[p];
      end
    end
  end

  always_comb begin
    dm      = '0;
    oeb     = '0;
    inp_dis = '0;
    for (int p = 0; p < N_PADS; p++) begin
      dm[3*p +: 3] = active_q[p][2:0];
      oeb[p]       = active_q[p][3];
      inp_dis[p]   = active_q[p][4];
    end
  end

`ifdef MPRJ_IO_SYNC_EN
  logic [N_PADS-1:0] sync1_q, sync1_d;
  logic [N_PADS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = io_in_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign io_in = sync2_q;
`else
  assign io_in = io_in_raw;
`endif

endmodule

// File: tb/tb_mprj_io_bank_ctrl.sv
// Self-checking bench for mprj_io_bank_ctrl: write table, per-edge staggered apply model,
// readback scoreboard, busy/reset corner sequences and pad-input path.
module tb_mprj_io_bank_ctrl;
  localparam int N  = 38;
  localparam int AW = 6;
  localparam int G  = 8;
  localparam int NG = 5;
  localparam logic [4:0] RCFG = 5'b01001;

  logic            wb_clk_i, wb_rst_i;
  logic            cfg_valid, cfg_ready, cfg_err;
  logic [AW-1:0]   cfg_pad, rd_pad;
  logic [4:0]      cfg_data, rd_data;
  logic            apply, apply_busy, apply_done;
  logic [N-1:0]    io_in_raw, io_in, oeb, inp_dis;
  logic [3*N-1:0]  dm;

  mprj_io_bank_ctrl #(.N_PADS(N), .PAD_AW(AW), .GROUP(G), .RST_DM(3'b001)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pad(cfg_pad), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .apply(apply), .apply_busy(apply_busy), .apply_done(apply_done),
    .rd_pad(rd_pad), .rd_data(rd_data), .io_in_raw(io_in_raw), .io_in(io_in),
    .dm(dm), .oeb(oeb), .inp_dis(inp_dis)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [AW-1:0] pad;
    logic [4:0]    data;
    logic          err;
  } wr_vec_t;

  int         checks = 0;
  int         fails  = 0;
  logic [4:0] m_sh  [N];
  logic [4:0] m_act [N];
  logic [4:0] sb_q [$];
  wr_vec_t    wr_tab [6];
  int         rb_tab [7];

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3*N-1:0] exp_dm();
    logic [3*N-1:0] r;
    for (int p = 0; p < N; p++) r[3*p +: 3] = m_act[p][2:0];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_oeb();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = m_act[p][3];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_inp();
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = m_act[p][4];
    return r;
  endfunction

  task automatic chk_pads(input string nm);
    chk({nm, "_dm"}, dm, exp_dm());
    chk({nm, "_oeb"}, oeb, exp_oeb());
    chk({nm, "_inp_dis"}, inp_dis, exp_inp());
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_sh[p]  = RCFG;
      m_act[p] = RCFG;
    end
  endtask

  // apply at E0; optional re-apply before edge reapply_at, reset at edge rst_at
  task automatic run_apply(input int reapply_at, input int rst_at, input bit hold_valid);
    apply = 1'b1;
    step();
    apply     = 1'b0;
    cfg_valid = hold_valid;
    chk("busy_e0", apply_busy, 1'b1);
    chk("done_e0", apply_done, 1'b0);
    chk("ready_e0", cfg_ready, 1'b0);
    for (int k = 1; k <= NG; k++) begin
      if (k == reapply_at) apply = 1'b1;
      if (k == rst_at) begin
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        apply    = 1'b0;
        model_reset();
        chk("rst_busy", apply_busy, 1'b0);
        chk("rst_done", apply_done, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_rd", rd_data, 5'd0);
        chk_pads("rst_pads");
        return;
      end
      step();
      apply = 1'b0;
      for (int p = 0; p < N; p++) if (p / G == k - 1) m_act[p] = m_sh[p];
      chk_pads($sformatf("apply_e%0d", k));
      chk($sformatf("busy_e%0d", k), apply_busy, (k < NG));
      chk($sformatf("done_e%0d", k), apply_done, (k == NG));
      chk($sformatf("ready_e%0d", k), cfg_ready, (k == NG));
    end
    step();
    chk("done_after", apply_done, 1'b0);
    chk("busy_after", apply_busy, 1'b0);
  endtask

  task automatic readback(input int pad);
    rd_pad = AW'(pad);
    sb_q.push_back((pad < N) ? m_act[pad] : 5'd0);
    step();
    chk($sformatf("rd_pad%0d", pad), rd_data, sb_q.pop_front());
  endtask

  initial begin
    wr_tab[0] = '{pad: 6'd5,  data: 5'b00110, err: 1'b0};
    wr_tab[1] = '{pad: 6'd0,  data: 5'b10011, err: 1'b0};
    wr_tab[2] = '{pad: 6'd37, data: 5'b01101, err: 1'b0};
    wr_tab[3] = '{pad: 6'd40, data: 5'b11111, err: 1'b1};
    wr_tab[4] = '{pad: 6'd63, data: 5'b10101, err: 1'b1};
    wr_tab[5] = '{pad: 6'd13, data: 5'b00010, err: 1'b0};
    rb_tab = '{5, 0, 37, 13, 40, 63, 6};

    wb_rst_i  = 1'b1;
    cfg_valid = 1'b0;
    cfg_pad   = '0;
    cfg_data  = '0;
    apply     = 1'b0;
    rd_pad    = 6'd40;
    io_in_raw = '0;
    model_reset();
    step();
    step();
    chk("rst_rd_data", rd_data, 5'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_apply_done", apply_done, 1'b0);
    chk("rst_apply_busy", apply_busy, 1'b0);
    chk("rst_dm_const", dm, {N{3'b001}});
    chk_pads("rst");
`ifdef MPRJ_IO_SYNC_EN
    chk("rst_io_in", io_in, '0);
`endif
    wb_rst_i = 1'b0;
    step();
    chk("hold_ready", cfg_ready, 1'b1);
    chk("hold_rd_data", rd_data, 5'd0);
    chk("hold_oeb_const", oeb, {N{1'b1}});
    chk_pads("hold");

    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_pad   = wr_tab[i].pad;
      cfg_data  = wr_tab[i].data;
      step();
      cfg_valid = 1'b0;
      chk($sformatf("wr%0d_err", i), cfg_err, wr_tab[i].err);
      if (!wr_tab[i].err) m_sh[wr_tab[i].pad] = wr_tab[i].data;
      step();
      chk($sformatf("wr%0d_err_clr", i), cfg_err, 1'b0);
    end
    chk_pads("shadow_only");

    run_apply(0, 0, 1'b0);
    chk("pad5_dm", dm[17:15], 3'b110);
    chk("pad5_oeb", oeb[5], 1'b0);
    chk("pad37_dm", dm[113:111], 3'b101);
    foreach (rb_tab[i]) readback(rb_tab[i]);

    cfg_valid = 1'b1;
    cfg_pad   = 6'd40;
    cfg_data  = 5'b10000;
    step();
    cfg_valid = 1'b0;
    chk("oor_err", cfg_err, 1'b1);
    step();
    chk("oor_err_clr", cfg_err, 1'b0);
    run_apply(0, 0, 1'b0);
    chk("oor_pad5_dm", dm[17:15], 3'b110);

    cfg_pad  = 6'd20;
    cfg_data = 5'b11010;
    run_apply(2, 0, 1'b1);
    cfg_valid = 1'b0;
    m_sh[20]  = 5'b11010;
    chk_pads("held_write_not_active");
    step();
    chk("no_queued_apply", apply_busy, 1'b0);

    cfg_valid = 1'b1;
    cfg_pad   = 6'd12;
    cfg_data  = 5'b10100;
    m_sh[12]  = 5'b10100;
    run_apply(0, 0, 1'b0);
    chk("pad20_dm", dm[62:60], 3'b010);
    chk("pad12_inp", inp_dis[12], 1'b1);
    readback(20);
    readback(12);

    run_apply(0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_done", apply_done, 1'b0);
      chk("post_rst_busy", apply_busy, 1'b0);
    end
    chk_pads("post_rst");
    readback(5);
    readback(20);

    io_in_raw = '0;
    step();
    step();
    io_in_raw[3] = 1'b1;
    #1;
`ifdef MPRJ_IO_SYNC_EN
    chk("sync_e0", io_in[3], 1'b0);
    step();
    chk("sync_e1", io_in[3], 1'b0);
    step();
    chk("sync_e2", io_in[3], 1'b1);
`else
    chk("comb_io_in", io_in, io_in_raw);
    chk("comb_io_in3", io_in[3], 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
